// File: rtl/exposure_pattern_sequencer_if.sv
// ---------------------------------------------------------------------------
// exposure_pattern_sequencer_if
//   Two-flag handshake between the frame sequencer and the ADC readout FSM.
//
//   Handshake: the sequencer raises FSMIND1 (readout request) when a frame's
//   exposure is complete. The ADC side answers with FSMIND1ACK. The sequencer
//   keeps FSMIND1 high until the ADC also raises FSMIND0 (ready for the next
//   exposure) and the minimum frame time has elapsed. On that cycle FSMIND1
//   drops and FSMIND0ACK rises. FSMIND0ACK then stays high until the next
//   readout request. Every flag change happens one clock after the
//   qualifying input is sampled.
//
//   Signals:
//     FSMIND1     sequencer -> ADC  readout request
//     FSMIND0ACK  sequencer -> ADC  acknowledge of FSMIND0
//     FSMIND0     ADC -> sequencer  ready for next exposure
//     FSMIND1ACK  ADC -> sequencer  readout request accepted
// ---------------------------------------------------------------------------
interface exposure_pattern_sequencer_if;
  logic FSMIND1;
  logic FSMIND0ACK;
  logic FSMIND0;
  logic FSMIND1ACK;

  modport master (output FSMIND1, output FSMIND0ACK,
                  input FSMIND0, input FSMIND1ACK);
  modport slave  (input FSMIND1, input FSMIND0ACK,
                  output FSMIND0, output FSMIND1ACK);
endinterface

// File: rtl/exposure_pattern_sequencer.sv
// ---------------------------------------------------------------------------
// exposure_pattern_sequencer
//   Frame sequencer for the coded-exposure imager, in the CLKMPRE domain.
//   A frame runs: first preload, then Num_Pat rounds of (pattern preload
//   with projector trigger, exposure), then last preload, then the readout
//   handshake with the ADC FSM.
//
//   Ports:
//     CLKMPRE, RESET         clock, async active-high reset
//     START, MODE_CONT       single-shot start / free-running mode
//     ABORT                  synchronous abort to IDLE
//     Exp_subc, Num_Pat      exposure cycles per pattern, patterns per frame
//     MIN_FRAME_TIME         minimum frame-start to frame-start spacing
//     PROJ_DELAY, TRIG_W     projector trigger offset and width
//     adc                    readout handshake (master side)
//     STREAM, CLKMPRE_EN     row-mask preload controls
//     OK_PIXRES_GLOB,
//     OK_DRAIN_B             pixel reset / drain controls
//     TRIGGER_PROJ           projector trigger
//     BUSY, fsm_stat         activity flag and state code
//     CntSubc                patterns completed in the current frame
// ---------------------------------------------------------------------------
module exposure_pattern_sequencer #(
  parameter int C_NUM_ROWS     = 160,
  parameter int C_FIRST_SETTLE = 2,
  parameter int C_N_SETTLE     = 268,
  parameter int C_CNT_W        = 32
) (
  input  logic               CLKMPRE,
  input  logic               RESET,
  input  logic               START,
  input  logic               MODE_CONT,
  input  logic               ABORT,
  input  logic [C_CNT_W-1:0] Exp_subc,
  input  logic [C_CNT_W-1:0] Num_Pat,
  input  logic [C_CNT_W-1:0] MIN_FRAME_TIME,
  input  logic [C_CNT_W-1:0] PROJ_DELAY,
  input  logic [C_CNT_W-1:0] TRIG_W,
  exposure_pattern_sequencer_if.master adc,
  output logic               STREAM,
  output logic               CLKMPRE_EN,
  output logic               OK_PIXRES_GLOB,
  output logic               OK_DRAIN_B,
  output logic               TRIGGER_PROJ,
  output logic               BUSY,
  output logic [7:0]         fsm_stat,
  output logic [C_CNT_W-1:0] CntSubc
);

  typedef enum logic [7:0] {
    IDLE      = 8'hAA,
    PRE_FIRST = 8'hFE,
    PRE_N     = 8'hFD,
    EXPOSE    = 8'hFC,
    PRE_LAST  = 8'hFB,
    HANDOFF   = 8'hFA,
    WAIT_NEXT = 8'hF8
  } state_t;

  localparam logic [C_CNT_W-1:0] ONE        = C_CNT_W'(1);
  localparam logic [C_CNT_W-1:0] ROWS       = C_CNT_W'(C_NUM_ROWS);
  localparam logic [C_CNT_W-1:0] FIRST_LAST = C_CNT_W'(C_NUM_ROWS + C_FIRST_SETTLE - 1);
  localparam logic [C_CNT_W-1:0] N_LAST     = C_CNT_W'(C_NUM_ROWS + C_N_SETTLE - 1);

  state_t             state_q, state_d;
  logic [C_CNT_W-1:0] c_q, c_d;
  logic [C_CNT_W-1:0] timer_q;
  logic [C_CNT_W-1:0] exp_l, np_l, pd_l, tw_l;
  logic [C_CNT_W-1:0] exp_eff, np_eff, tw_eff;
  logic               frame_start;
  logic               preload_d;
  logic               trig_d;

  // Zero-valued settings behave as one.
  assign exp_eff = (exp_l == '0) ? ONE : exp_l;
  assign np_eff  = (np_l  == '0) ? ONE : np_l;
  assign tw_eff  = (tw_l  == '0) ? ONE : tw_l;

  always_comb begin
    state_d     = state_q;
    c_d         = c_q + ONE;
    frame_start = 1'b0;
    case (state_q)
      IDLE: begin
        c_d = '0;
        if (MODE_CONT || START) begin
          state_d     = PRE_FIRST;
          frame_start = 1'b1;
        end
      end
      PRE_FIRST: if (c_q == FIRST_LAST) begin state_d = PRE_N; c_d = '0; end
      PRE_N:     if (c_q == N_LAST)     begin state_d = EXPOSE; c_d = '0; end
      EXPOSE: begin
        if (c_q == exp_eff - ONE) begin
          // CntSubc already counts the pattern just exposed.
          state_d = (CntSubc < np_eff) ? PRE_N : PRE_LAST;
          c_d     = '0;
        end
      end
      PRE_LAST:  if (c_q == FIRST_LAST) begin state_d = HANDOFF; c_d = '0; end
      HANDOFF: begin
        c_d = '0;
        if (adc.FSMIND1ACK) state_d = WAIT_NEXT;
      end
      WAIT_NEXT: begin
        c_d = '0;
        if (adc.FSMIND0 && (timer_q == '0)) begin
          if (MODE_CONT) begin
            state_d     = PRE_FIRST;
            frame_start = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        c_d     = '0;
      end
    endcase
    if (ABORT) begin
      state_d     = IDLE;
      c_d         = '0;
      frame_start = 1'b0;
    end
  end

  assign preload_d = (state_d == PRE_FIRST) || (state_d == PRE_N) || (state_d == PRE_LAST);
  // Window check written as a difference so PROJ_DELAY+TRIG_W cannot overflow.
  assign trig_d = (state_d == PRE_N) && (c_d >= pd_l) && ((c_d - pd_l) < tw_eff);

  always_ff @(posedge CLKMPRE or posedge RESET) begin
    if (RESET) begin
      state_q        <= IDLE;
      c_q            <= '0;
      timer_q        <= '0;
      exp_l          <= '0;
      np_l           <= '0;
      pd_l           <= '0;
      tw_l           <= '0;
      STREAM         <= 1'b0;
      CLKMPRE_EN     <= 1'b0;
      OK_PIXRES_GLOB <= 1'b1;
      OK_DRAIN_B     <= 1'b0;
      TRIGGER_PROJ   <= 1'b0;
      BUSY           <= 1'b0;
      fsm_stat       <= IDLE;
      CntSubc        <= '0;
      adc.FSMIND1    <= 1'b0;
      adc.FSMIND0ACK <= 1'b0;
    end else begin
      state_q      <= state_d;
      c_q          <= c_d;
      fsm_stat     <= state_d;
      BUSY         <= (state_d != IDLE);
      CLKMPRE_EN   <= preload_d;
      STREAM       <= preload_d && (c_d < ROWS);
      TRIGGER_PROJ <= trig_d;

      if (frame_start) begin
        timer_q <= MIN_FRAME_TIME;
      end else if ((state_q != IDLE) && (timer_q != '0)) begin
        timer_q <= timer_q - ONE;
      end

      if (frame_start) begin
        exp_l          <= Exp_subc;
        np_l           <= Num_Pat;
        pd_l           <= PROJ_DELAY;
        tw_l           <= TRIG_W;
        CntSubc        <= '0;
        OK_PIXRES_GLOB <= 1'b1;
        OK_DRAIN_B     <= 1'b0;
      end
      if ((state_q == PRE_N) && (state_d == EXPOSE)) CntSubc <= CntSubc + ONE;
      if (state_d == EXPOSE) begin
        OK_PIXRES_GLOB <= 1'b0;
        OK_DRAIN_B     <= 1'b1;
      end
      if ((state_q == PRE_LAST) && (state_d == HANDOFF)) begin
        OK_DRAIN_B     <= 1'b0;
        adc.FSMIND1    <= 1'b1;
        adc.FSMIND0ACK <= 1'b0;
      end
      if ((state_q == WAIT_NEXT) && (state_d != WAIT_NEXT) && !ABORT) begin
        adc.FSMIND1    <= 1'b0;
        adc.FSMIND0ACK <= 1'b1;
      end
      // Abort returns outputs to reset values; FSMIND0ACK keeps its level.
      if (ABORT) begin
        OK_PIXRES_GLOB <= 1'b1;
        OK_DRAIN_B     <= 1'b0;
        CntSubc        <= '0;
        adc.FSMIND1    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_exposure_pattern_sequencer.sv
// ---------------------------------------------------------------------------
// tb_exposure_pattern_sequencer
//   Bench for exposure_pattern_sequencer with C_NUM_ROWS=4, C_FIRST_SETTLE=2,
//   C_N_SETTLE=3. A frame-level model expands each frame into per-cycle
//   expected output records; a compare process checks them every cycle.
// ---------------------------------------------------------------------------
module tb_exposure_pattern_sequencer;
  localparam int ROWS      = 4;
  localparam int FS        = 2;
  localparam int NS        = 3;
  localparam int W         = 32;
  localparam int FIRST_LEN = ROWS + FS;
  localparam int N_LEN     = ROWS + NS;

  // Record layout: stat[47:40] stream en pix drain trig ind1 ack busy cnt[31:0]
  localparam int B_STREAM = 39;
  localparam int B_TRIG   = 35;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0, mode_cont = 1'b0, abort = 1'b0;
  logic [W-1:0] exp_subc = '0, num_pat = '0, min_ft = '0, proj_delay = '0, trig_w = '0;
  logic         stream, clkmpre_en, pixres, drain_b, trig, busy;
  logic [7:0]   fsm_stat;
  logic [W-1:0] cnt_subc;

  logic [47:0]  exp_q[$];
  logic [47:0]  frame_q[$];
  int           checks = 0;
  int           errors = 0;
  logic         ack_state = 1'b0;

  exposure_pattern_sequencer_if adc_if ();

  exposure_pattern_sequencer #(
    .C_NUM_ROWS(ROWS), .C_FIRST_SETTLE(FS), .C_N_SETTLE(NS), .C_CNT_W(W)
  ) dut (
    .CLKMPRE(clk), .RESET(rst), .START(start), .MODE_CONT(mode_cont), .ABORT(abort),
    .Exp_subc(exp_subc), .Num_Pat(num_pat), .MIN_FRAME_TIME(min_ft),
    .PROJ_DELAY(proj_delay), .TRIG_W(trig_w), .adc(adc_if),
    .STREAM(stream), .CLKMPRE_EN(clkmpre_en), .OK_PIXRES_GLOB(pixres),
    .OK_DRAIN_B(drain_b), .TRIGGER_PROJ(trig), .BUSY(busy),
    .fsm_stat(fsm_stat), .CntSubc(cnt_subc)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model ----------------
  function automatic logic [47:0] rec(input logic [7:0] st, input logic s, input logic e,
                                      input logic p, input logic d, input logic t,
                                      input logic i1, input logic a, input logic b,
                                      input int cnt);
    return {st, s, e, p, d, t, i1, a, b, W'(cnt)};
  endfunction

  function automatic int frame_len(input int ex, input int np_in);
    int np, e;
    np = (np_in == 0) ? 1 : np_in;
    e  = (ex == 0) ? 1 : ex;
    return 2 * FIRST_LEN + np * (N_LEN + e);
  endfunction

  // One frame from the PRE_FIRST entry cycle through h HANDOFF and w WAIT cycles.
  task automatic build_frame(input int ex, input int np_in, input int pd, input int tw,
                             input logic ack_in, input int h, input int w);
    int np, e, twe;
    np  = (np_in == 0) ? 1 : np_in;
    e   = (ex == 0) ? 1 : ex;
    twe = (tw == 0) ? 1 : tw;
    for (int c = 0; c < FIRST_LEN; c++)
      frame_q.push_back(rec(8'hFE, c < ROWS, 1, 1, 0, 0, 0, ack_in, 1, 0));
    for (int p = 1; p <= np; p++) begin
      for (int c = 0; c < N_LEN; c++)
        frame_q.push_back(rec(8'hFD, c < ROWS, 1, p == 1, p != 1,
                              (c >= pd) && (c < pd + twe), 0, ack_in, 1, p - 1));
      for (int c = 0; c < e; c++)
        frame_q.push_back(rec(8'hFC, 0, 0, 0, 1, 0, 0, ack_in, 1, p));
    end
    for (int c = 0; c < FIRST_LEN; c++)
      frame_q.push_back(rec(8'hFB, c < ROWS, 1, 0, 1, 0, 0, ack_in, 1, np));
    repeat (h) frame_q.push_back(rec(8'hFA, 0, 0, 0, 0, 0, 1, 0, 1, np));
    repeat (w) frame_q.push_back(rec(8'hF8, 0, 0, 0, 0, 0, 1, 0, 1, np));
  endtask

  function automatic int count_bit(input int pos);
    int n = 0;
    foreach (frame_q[i]) if (frame_q[i][pos]) n++;
    return n;
  endfunction

  function automatic int count_stat(input logic [7:0] st);
    int n = 0;
    foreach (frame_q[i]) if (frame_q[i][47:40] == st) n++;
    return n;
  endfunction

  function automatic int first_stat(input logic [7:0] st);
    for (int i = 0; i < frame_q.size(); i++) if (frame_q[i][47:40] == st) return i;
    return -1;
  endfunction

  function automatic int first_bit(input int pos);
    for (int i = 0; i < frame_q.size(); i++) if (frame_q[i][pos]) return i;
    return -1;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [47:0] act, input logic [47:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [47:0] act_vec();
    return {fsm_stat, stream, clkmpre_en, pixres, drain_b, trig,
            adc_if.FSMIND1, adc_if.FSMIND0ACK, busy, cnt_subc};
  endfunction

  always @(negedge clk) begin : cmp
    logic [47:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("trace", act_vec(), e);
    end
  end

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() > 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    #1;
    check({"drain_", name}, 48'(exp_q.size()), 48'd0);
    exp_q.delete();
  endtask

  // ---------------- drivers ----------------
  // Single-shot frame. FSMIND1ACK rises a cycles into HANDOFF, FSMIND0
  // rises b cycles into WAIT_NEXT; MIN_FRAME_TIME is 0.
  task automatic run_single(input int ex, input int np_in, input int pd, input int tw,
                            input int a, input int b);
    int len, np;
    np         = (np_in == 0) ? 1 : np_in;
    exp_subc   = W'(ex);
    num_pat    = W'(np_in);
    proj_delay = W'(pd);
    trig_w     = W'(tw);
    min_ft     = '0;
    mode_cont  = 1'b0;
    adc_if.FSMIND1ACK = 1'b0;
    adc_if.FSMIND0    = 1'b0;
    len = frame_len(ex, np_in);
    frame_q.delete();
    build_frame(ex, np_in, pd, tw, ack_state, a + 1, b + 1);
    repeat (2) frame_q.push_back(rec(8'hAA, 0, 0, 0, 0, 0, 0, 1, 0, np));
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    foreach (frame_q[i]) exp_q.push_back(frame_q[i]);
    repeat (len + a) @(posedge clk);
    #1 adc_if.FSMIND1ACK = 1'b1;
    repeat (1 + b) @(posedge clk);
    #1 adc_if.FSMIND0 = 1'b1;
    wait_drain("single");
    ack_state = 1'b1;
  endtask

  task automatic start_frame_prefix(input int ex, input int np_in, input int keep);
    exp_subc   = W'(ex);
    num_pat    = W'(np_in);
    proj_delay = W'(2);
    trig_w     = W'(3);
    min_ft     = '0;
    frame_q.delete();
    build_frame(ex, np_in, 2, 3, ack_state, 1, 1);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < keep; i++) exp_q.push_back(frame_q[i]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w1, len1;
    adc_if.FSMIND0    = 1'b0;
    adc_if.FSMIND1ACK = 1'b0;

    // Asynchronous reset, checked before any clock edge.
    #1 rst = 1'b1;
    #1 check("reset_async", act_vec(), rec(8'hAA, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("idle_hold", act_vec(), rec(8'hAA, 0, 0, 1, 0, 0, 0, 0, 0, 0));

    // Baseline frame: 2 patterns, exposure 5, trigger c=2..4.
    run_single(5, 2, 2, 3, 0, 0);
    check("model_len", 48'(first_stat(8'hFA)), 48'd36);
    check("model_trig_cnt", 48'(count_bit(B_TRIG)), 48'd6);
    check("model_stream_cnt", 48'(count_bit(B_STREAM)), 48'd16);

    // Trigger delay beyond PRE_N length, slow handshake.
    run_single(1, 1, 7, 3, 2, 3);
    check("model_no_pulse", 48'(count_bit(B_TRIG)), 48'd0);

    // Truncated pulse: c=5..6 only.
    run_single(2, 1, 5, 9, 0, 0);
    check("model_trunc_cnt", 48'(count_bit(B_TRIG)), 48'd2);
    check("model_trunc_pos", 48'(first_bit(B_TRIG)), 48'd11);

    // Zero settings act as one: one pattern, 1-cycle exposure, 1-cycle trigger.
    run_single(0, 0, 0, 0, 1, 0);
    check("model_zero_len", 48'(first_stat(8'hFA)), 48'd20);
    check("model_zero_expose", 48'(count_stat(8'hFC)), 48'd1);

    // Continuous mode, MIN_FRAME_TIME=100; Num_Pat and MIN change mid-frame.
    exp_subc = W'(5); num_pat = W'(2); proj_delay = W'(2); trig_w = W'(3);
    min_ft = W'(100);
    adc_if.FSMIND1ACK = 1'b1;
    adc_if.FSMIND0    = 1'b1;
    len1 = frame_len(5, 2);
    w1   = (100 - len1 > 1) ? 100 - len1 : 1;
    frame_q.delete();
    build_frame(5, 2, 2, 3, ack_state, 1, w1);
    check("model_cont_period", 48'(frame_q.size()), 48'd101);
    build_frame(5, 1, 2, 3, 1'b1, 1, 1);
    repeat (2) frame_q.push_back(rec(8'hAA, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    mode_cont = 1'b1;
    @(posedge clk);
    #1 foreach (frame_q[i]) exp_q.push_back(frame_q[i]);
    repeat (10) @(posedge clk);
    #1 begin num_pat = W'(1); min_ft = '0; end
    repeat (100) @(posedge clk);
    #1 mode_cont = 1'b0;
    wait_drain("cont");
    ack_state = 1'b1;

    // Abort in EXPOSE (c=3), then ABORT together with START stays IDLE.
    adc_if.FSMIND1ACK = 1'b0;
    adc_if.FSMIND0    = 1'b0;
    start_frame_prefix(20, 1, 17);
    repeat (2) exp_q.push_back(rec(8'hAA, 0, 0, 1, 0, 0, 0, ack_state, 0, 0));
    repeat (16) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 begin abort = 1'b0; start = 1'b0; end
    wait_drain("abort");

    // Async reset in PRE_N (c=3, trigger high).
    start_frame_prefix(5, 2, 10);
    repeat (9) @(posedge clk);
    #7 rst = 1'b1;
    #1 check("reset_mid_pre_n", act_vec(), rec(8'hAA, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    ack_state = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("idle_after_reset", act_vec(), rec(8'hAA, 0, 0, 1, 0, 0, 0, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exposure_pattern_sequencer.md
# exposure_pattern_sequencer

Parametrised frame sequencer for the coded-exposure imager. Runs in the mask-preload clock domain and drives row-mask preloading (STREAM/CLKMPRE_EN), global pixel reset, drain, and a projector trigger aligned to each pattern preload. It performs the two-flag handshake with the ADC readout FSM on the motherboard. Compared with the previous generation it adds parametrised row count and settle lengths, a projector trigger in the same clock domain with programmable width, frame-start latching of all run-time settings, continuous or single-shot operation, and a clean abort.

## Interface
- C_NUM_ROWS, 160, mask rows preloaded per pattern
- C_FIRST_SETTLE, 2, idle cycles after the first/last preload
- C_N_SETTLE, 268, idle cycles after each mid-frame pattern preload
- C_CNT_W, 32, width of the count/timer registers and inputs
- CLKMPRE  in  1  sole clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- START  in  1  single-shot mode: level-sampled in IDLE to begin one frame
- MODE_CONT  in  1  1 = free-running frames, 0 = single-shot
- ABORT  in  1  synchronous abort to IDLE
- Exp_subc  in  C_CNT_W  exposure cycles per pattern
- Num_Pat  in  C_CNT_W  patterns per frame (0 treated as 1)
- MIN_FRAME_TIME  in  C_CNT_W  minimum cycles from frame start to next frame start
- PROJ_DELAY  in  C_CNT_W  cycles from start of a pattern preload to trigger rise
- TRIG_W  in  C_CNT_W  trigger high cycles (0 treated as 1)
- FSMIND0  in  1  ADC side ready for next exposure
- FSMIND1ACK  in  1  ADC side accepted readout request
- STREAM, CLKMPRE_EN, OK_PIXRES_GLOB, OK_DRAIN_B, TRIGGER_PROJ  out  1  pixel/projector controls
- FSMIND1  out  1  readout request to ADC FSM
- FSMIND0ACK  out  1  acknowledge of FSMIND0
- BUSY  out  1  high in every state except IDLE
- fsm_stat  out  8  state code
- CntSubc  out  C_CNT_W  patterns completed in the current frame

## Operation
- All outputs are registered. Reset values:
  - OK_PIXRES_GLOB = 1.
  - STREAM, CLKMPRE_EN, OK_DRAIN_B, TRIGGER_PROJ, FSMIND1, FSMIND0ACK, BUSY = 0.
  - CntSubc = 0.
  - fsm_stat = 8'hAA (IDLE).
- States and fsm_stat codes: IDLE AA, PRE_FIRST FE, PRE_N FD, EXPOSE FC, PRE_LAST FB, HANDOFF FA, WAIT_NEXT F8. Counter c resets to 0 on every state entry.
- IDLE → PRE_FIRST when MODE_CONT=1, or when START=1.
  - On this transition, latch Exp_subc, Num_Pat, PROJ_DELAY and TRIG_W.
  - Load the frame timer with MIN_FRAME_TIME.
  - Clear CntSubc.
  - Set OK_PIXRES_GLOB=1 and OK_DRAIN_B=0.
- PRE_FIRST and PRE_LAST, length C_NUM_ROWS+C_FIRST_SETTLE cycles:
  - STREAM=1 for c < C_NUM_ROWS, else 0.
  - CLKMPRE_EN=1 throughout.
  - PRE_FIRST → PRE_N.
  - PRE_LAST → HANDOFF; OK_DRAIN_B clears on this exit.
- PRE_N, length C_NUM_ROWS+C_N_SETTLE cycles:
  - STREAM and CLKMPRE_EN behave as above.
  - TRIGGER_PROJ=1 for PROJ_DELAY ≤ c < PROJ_DELAY+TRIG_W. The pulse is truncated at state exit.
  - No pulse if PROJ_DELAY ≥ state length.
  - On exit, CntSubc increments and the state moves to EXPOSE.
- EXPOSE, length max(Exp_subc,1) cycles:
  - OK_PIXRES_GLOB=0, OK_DRAIN_B=1.
  - Exit → PRE_N if CntSubc < Num_Pat, else → PRE_LAST.
- HANDOFF:
  - FSMIND1=1 and FSMIND0ACK=0.
  - → WAIT_NEXT on the first cycle FSMIND1ACK=1.
- WAIT_NEXT: FSMIND1 is held at 1 until FSMIND0=1 and timer==0 in the same cycle. Then:
  - FSMIND1 ← 0 and FSMIND0ACK ← 1; FSMIND0ACK is held until the next HANDOFF.
  - Next state is PRE_FIRST if MODE_CONT=1 (relatch settings, reload timer), else IDLE.
- Frame timer: decrements every non-IDLE cycle and saturates at 0.
- ABORT=1 (any state):
  - Next cycle: IDLE with reset output values, except FSMIND0ACK, which is held.
  - ABORT overrides START.
- Illegal state encoding: recover to IDLE in one cycle.

## Timing
- START sampled at edge k: PRE_FIRST is active and STREAM=1 from edge k+1.
- Frame length up to HANDOFF entry: 2·(C_NUM_ROWS+C_FIRST_SETTLE) + Np·(C_NUM_ROWS+C_N_SETTLE+max(Exp_subc,1)) cycles, where Np = max(Num_Pat,1).
- Handshake: each flag change occurs one cycle after the qualifying input is sampled. Inputs are synchronous to CLKMPRE.
- Changes to Exp_subc, Num_Pat, PROJ_DELAY and TRIG_W mid-frame have no effect until the next frame start.
- CntSubc range is 1..Np, held from the end of the last PRE_N until the next frame start.

## Test plan
- Defaults, C_NUM_ROWS=4, C_N_SETTLE=3, Num_Pat=2, Exp_subc=5, single START → two FE→FD→FC passes, then FB and FA; STREAM high for 4 cycles per preload; total 2·6+2·12 = 36 cycles to HANDOFF.
- PROJ_DELAY=2, TRIG_W=3 → TRIGGER_PROJ high at c=2..4 of each PRE_N. PROJ_DELAY=7 → no pulse. PROJ_DELAY=5, TRIG_W=9 → pulse truncated to c=5..6.
- MIN_FRAME_TIME=100 with FSMIND0 held high → next PRE_FIRST no earlier than 100 cycles after the previous one. MIN_FRAME_TIME=0 → PRE_FIRST one cycle after FSMIND0 is sampled.
- Num_Pat=0 and Exp_subc=0 → one pattern, EXPOSE lasts 1 cycle, CntSubc=1.
- ABORT asserted mid-EXPOSE → next cycle IDLE, OK_PIXRES_GLOB=1, BUSY=0. Async RESET pulse mid-PRE_N → all outputs at reset values immediately.
- MODE_CONT=1 with Num_Pat changed mid-frame → the current frame uses the old value and the next frame uses the new one.
